// File: rtl/horner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : horner_pkg                                             |
// | Description : Frame-layout constants and FSM state type shared by    |
// |               the Horner input-side frame sequencer.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package horner_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int LANES      = 4;
   localparam int BEAT_W     = LANES * DATA_WIDTH;
   localparam int ORI_NUM    = 8;
   localparam int INT_NUM    = 35;
   localparam int LAY_NUM    = 5;
   localparam int CNT_W      = 16;

   // Section lengths of one frame (after the single header beat)
   localparam int WEIGHT_NUM = 3 * ORI_NUM + INT_NUM - LAY_NUM + 3;
   localparam int VEC_NUM    = ORI_NUM + INT_NUM + LAY_NUM + 3;
   localparam int MAT_ROWS   = 3;

   localparam int W_ADDR_W   = $clog2(WEIGHT_NUM);
   localparam int V_ADDR_W   = $clog2(VEC_NUM);
   localparam int M_ROW_W    = 2;

   // The shared section counter must cover the longest section
   localparam int SEC_W      = (W_ADDR_W > V_ADDR_W) ? W_ADDR_W : V_ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_LOAD_M = 3'd2,
      ST_LOAD_V = 3'd3,
      ST_START  = 3'd4,
      ST_WAIT   = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/horner_sec_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : horner_sec_cnt                                         |
// | Description : Modulo-N beat counter. Counts 0..last_idx on inc and   |
// |               wraps to 0, flagging the wrapping beat with tc.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module horner_sec_cnt #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] last_idx,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Terminal count fires on the increment that consumes the last index
   always_comb begin
      tc      = inc && (count_q == last_idx);
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = tc ? '0 : (count_q + WIDTH'(1));
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/horner_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : horner_frame_ctrl                                      |
// | Description : Parses AXI-Stream frames (header, weights, matrix rows,|
// |               vector) into the engine stores, then starts the engine |
// |               and holds the stream off until it reports done.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module horner_frame_ctrl
   import horner_pkg::*;
(
   input  logic                s00_axis_aclk,
   input  logic                s00_axis_areset,
   input  logic [BEAT_W-1:0]   s00_axis_tdata,
   input  logic                s00_axis_tvalid,
   output logic                s00_axis_tready,
   input  logic                s00_axis_tlast,
   output logic                w_we,
   output logic [W_ADDR_W-1:0] w_addr,
   output logic                m_we,
   output logic [M_ROW_W-1:0]  m_row,
   output logic                v_we,
   output logic [V_ADDR_W-1:0] v_addr,
   output logic [BEAT_W-1:0]   wr_data,
   output logic [CNT_W-1:0]    cal_num,
   output logic                eng_start,
   input  logic                eng_done,
   output logic                busy,
   output logic                err_early_last,
   output logic [7:0]          frame_cnt
);

   state_t                state_q, state_d;
   logic                  w_we_q, w_we_d;
   logic                  m_we_q, m_we_d;
   logic                  v_we_q, v_we_d;
   logic [W_ADDR_W-1:0]   w_addr_q, w_addr_d;
   logic [M_ROW_W-1:0]    m_row_q, m_row_d;
   logic [V_ADDR_W-1:0]   v_addr_q, v_addr_d;
   logic [BEAT_W-1:0]     wr_data_q, wr_data_d;
   logic [CNT_W-1:0]      cal_num_q, cal_num_d;
   logic                  eng_start_q, eng_start_d;
   logic                  err_q, err_d;
   logic [7:0]            frame_cnt_q, frame_cnt_d;

   logic                  w_tready;
   logic                  w_accept;
   logic                  w_in_load;
   logic                  w_final_beat;
   logic                  w_early_last;
   logic                  w_cnt_clr;
   logic                  w_cnt_inc;
   logic                  w_cnt_tc;
   logic [SEC_W-1:0]      w_cnt;
   logic [SEC_W-1:0]      w_sec_last;

   // Handshake and framing qualifiers derived from the current state
   always_comb begin
      w_in_load    = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_M) ||
                     (state_q == ST_LOAD_V);
      w_tready     = (state_q == ST_IDLE) || w_in_load;
      w_accept     = s00_axis_tvalid && w_tready;
      w_cnt_inc    = w_accept && w_in_load;
      // tlast is only legal on the closing vector beat; anywhere else it aborts
      w_final_beat = (state_q == ST_LOAD_V) && w_cnt_tc;
      w_early_last = w_accept && s00_axis_tlast && !w_final_beat;
      w_cnt_clr    = w_early_last || (state_q == ST_IDLE);
   end

   // Section length for the shared counter follows the load state
   always_comb begin
      w_sec_last = '0;
      case (state_q)
         ST_LOAD_W: w_sec_last = SEC_W'(WEIGHT_NUM - 1);
         ST_LOAD_M: w_sec_last = SEC_W'(MAT_ROWS - 1);
         ST_LOAD_V: w_sec_last = SEC_W'(VEC_NUM - 1);
         default:   w_sec_last = '0;
      endcase
   end

   horner_sec_cnt #(
      .WIDTH (SEC_W)
   ) u_sec_cnt (
      .clk      (s00_axis_aclk),
      .rst      (s00_axis_areset),
      .clr      (w_cnt_clr),
      .inc      (w_cnt_inc),
      .last_idx (w_sec_last),
      .count    (w_cnt),
      .tc       (w_cnt_tc)
   );

   // Next-state, write steering and status updates
   always_comb begin
      state_d     = state_q;
      w_we_d      = 1'b0;
      m_we_d      = 1'b0;
      v_we_d      = 1'b0;
      w_addr_d    = w_addr_q;
      m_row_d     = m_row_q;
      v_addr_d    = v_addr_q;
      wr_data_d   = wr_data_q;
      cal_num_d   = cal_num_q;
      eng_start_d = 1'b0;
      err_d       = err_q | w_early_last;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept && !s00_axis_tlast) begin
               cal_num_d = s00_axis_tdata[CNT_W-1:0];
               state_d   = ST_LOAD_W;
            end
         end
         ST_LOAD_W: begin
            if (w_early_last) begin
               state_d = ST_IDLE;
            end else if (w_accept) begin
               w_we_d    = 1'b1;
               w_addr_d  = w_cnt[W_ADDR_W-1:0];
               wr_data_d = s00_axis_tdata;
               if (w_cnt_tc) state_d = ST_LOAD_M;
            end
         end
         ST_LOAD_M: begin
            if (w_early_last) begin
               state_d = ST_IDLE;
            end else if (w_accept) begin
               m_we_d    = 1'b1;
               m_row_d   = w_cnt[M_ROW_W-1:0];
               wr_data_d = s00_axis_tdata;
               if (w_cnt_tc) state_d = ST_LOAD_V;
            end
         end
         ST_LOAD_V: begin
            if (w_early_last) begin
               state_d = ST_IDLE;
            end else if (w_accept) begin
               v_we_d    = 1'b1;
               v_addr_d  = w_cnt[V_ADDR_W-1:0];
               wr_data_d = s00_axis_tdata;
               if (w_cnt_tc) state_d = ST_START;
            end
         end
         ST_START: begin
            // Registered so the pulse lands the cycle after the last v_we
            eng_start_d = 1'b1;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset abandons any frame in flight
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state_q     <= ST_IDLE;
         w_we_q      <= 1'b0;
         m_we_q      <= 1'b0;
         v_we_q      <= 1'b0;
         w_addr_q    <= '0;
         m_row_q     <= '0;
         v_addr_q    <= '0;
         wr_data_q   <= '0;
         cal_num_q   <= '0;
         eng_start_q <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         w_we_q      <= w_we_d;
         m_we_q      <= m_we_d;
         v_we_q      <= v_we_d;
         w_addr_q    <= w_addr_d;
         m_row_q     <= m_row_d;
         v_addr_q    <= v_addr_d;
         wr_data_q   <= wr_data_d;
         cal_num_q   <= cal_num_d;
         eng_start_q <= eng_start_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign s00_axis_tready = w_tready;
   assign w_we            = w_we_q;
   assign w_addr          = w_addr_q;
   assign m_we            = m_we_q;
   assign m_row           = m_row_q;
   assign v_we            = v_we_q;
   assign v_addr          = v_addr_q;
   assign wr_data         = wr_data_q;
   assign cal_num         = cal_num_q;
   assign eng_start       = eng_start_q;
   assign busy            = (state_q != ST_IDLE);
   assign err_early_last  = err_q;
   assign frame_cnt       = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_horner_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_horner_frame_ctrl                                   |
// | Description : Randomised scoreboard bench for horner_frame_ctrl.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_horner_frame_ctrl;
   import horner_pkg::*;

   localparam int N_BEATS  = 1 + WEIGHT_NUM + MAT_ROWS + VEC_NUM;
   localparam int DONE_DLY = 20;

   logic                clk = 1'b0;
   logic                rst;
   logic [BEAT_W-1:0]   tdata;
   logic                tvalid;
   logic                tlast;
   logic                tready;
   logic                w_we, m_we, v_we;
   logic [W_ADDR_W-1:0] w_addr;
   logic [M_ROW_W-1:0]  m_row;
   logic [V_ADDR_W-1:0] v_addr;
   logic [BEAT_W-1:0]   wr_data;
   logic [CNT_W-1:0]    cal_num;
   logic                eng_start;
   logic                done_eng, done_inj;
   logic                eng_done;
   logic                busy;
   logic                err_early_last;
   logic [7:0]          frame_cnt;

   assign eng_done = done_eng | done_inj;

   always #5 clk = ~clk;

   horner_frame_ctrl dut (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .s00_axis_tdata  (tdata),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tready (tready),
      .s00_axis_tlast  (tlast),
      .w_we            (w_we),
      .w_addr          (w_addr),
      .m_we            (m_we),
      .m_row           (m_row),
      .v_we            (v_we),
      .v_addr          (v_addr),
      .wr_data         (wr_data),
      .cal_num         (cal_num),
      .eng_start       (eng_start),
      .eng_done        (eng_done),
      .busy            (busy),
      .err_early_last  (err_early_last),
      .frame_cnt       (frame_cnt)
   );

   typedef struct {
      int              kind;   // 0 weight, 1 matrix row, 2 vector
      int              addr;
      logic [BEAT_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_frames = 0;
   bit   engine_active = 1'b0;
   bit   expect_start = 1'b0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: frame position b decides store and index directly
   task automatic model_accept(input int b, input logic [BEAT_W-1:0] d, input bit last);
      exp_t e;
      if (last && b != N_BEATS - 1) return;
      if (b == 0) return;
      e.data = d;
      if (b <= WEIGHT_NUM) begin
         e.kind = 0; e.addr = b - 1;
      end else if (b <= WEIGHT_NUM + MAT_ROWS) begin
         e.kind = 1; e.addr = b - 1 - WEIGHT_NUM;
      end else begin
         e.kind = 2; e.addr = b - 1 - WEIGHT_NUM - MAT_ROWS;
      end
      exp_q.push_back(e);
   endtask

   // Monitor: pops the scoreboard on every write strobe, tracks start timing
   int   n_we, got_kind, got_addr;
   bit   saw_vlast;
   exp_t got_e;
   always @(negedge clk) begin
      if (mon_en) begin
         n_we      = int'(w_we) + int'(m_we) + int'(v_we);
         saw_vlast = 1'b0;
         if (n_we > 1) begin
            check("we_onehot", 64'(n_we), 64'd1);
         end else if (n_we == 1) begin
            got_kind = w_we ? 0 : (m_we ? 1 : 2);
            got_addr = w_we ? int'(w_addr) : (m_we ? int'(m_row) : int'(v_addr));
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got kind %0d addr %0d, required no write (t=%0t)",
                        got_kind, got_addr, $time);
            end else begin
               got_e = exp_q.pop_front();
               check("we_kind", 64'(got_kind), 64'(got_e.kind));
               check("we_addr", 64'(got_addr), 64'(got_e.addr));
               check("wr_data", wr_data, got_e.data);
            end
            saw_vlast = (got_kind == 2) && (got_addr == VEC_NUM - 1);
         end
         if (eng_start || expect_start)
            check("eng_start_timing", 64'(eng_start), 64'(expect_start));
         expect_start = saw_vlast;
      end
   end

   // Engine model: answers each start with done after DONE_DLY cycles
   initial begin
      done_eng = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && eng_start && !rst) begin
            engine_active = 1'b1;
            for (int i = 0; i < DONE_DLY; i++) begin
               @(negedge clk);
               check("tready_in_wait", 64'(tready), 64'd0);
               check("busy_in_wait", 64'(busy), 64'd1);
            end
            done_eng = 1'b1;
            @(negedge clk);
            done_eng = 1'b0;
            exp_frames++;
            check("frame_cnt", 64'(frame_cnt), 64'(exp_frames & 255));
            check("busy_after_done", 64'(busy), 64'd0);
            check("tready_after_done", 64'(tready), 64'd1);
            engine_active = 1'b0;
         end
      end
   end

   task automatic check_idle(input string tag, input bit err_exp, input int fc_exp);
      check({tag, "_tready"}, 64'(tready), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_strobes"}, 64'({w_we, m_we, v_we}), 64'd0);
      check({tag, "_eng_start"}, 64'(eng_start), 64'd0);
      check({tag, "_err"}, 64'(err_early_last), 64'(err_exp));
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(fc_exp));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_frames = 0;
   endtask

   // Drive one frame; early_b/rst_b/inj_b select a fault point (-1 = none)
   task automatic send_frame(input int cal, input int gap_mode, input int early_b,
                             input int rst_b, input int inj_b, input bit last_final);
      int cyc = 0;
      int guard;
      logic [BEAT_W-1:0] d;
      bit last;
      for (int b = 0; b < N_BEATS; b++) begin
         d = {$urandom, $urandom};
         if (b == 0) d[CNT_W-1:0] = cal[CNT_W-1:0];
         last = (b == early_b) || (b == N_BEATS - 1 && last_final);
         @(negedge clk);
         while ((gap_mode == 1 && cyc % 3 == 2) ||
                (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            tvalid = 1'b0;
            cyc++;
            @(negedge clk);
         end
         tvalid = 1'b1;
         tdata  = d;
         tlast  = last;
         guard  = 0;
         while (!tready && guard < 300) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 300) begin
            check("tready_timeout", 64'd0, 64'd1);
            tvalid = 1'b0;
            return;
         end
         model_accept(b, d, last);
         if (b == inj_b) done_inj = 1'b1;
         @(posedge clk);
         #1;
         tvalid   = 1'b0;
         tlast    = 1'b0;
         done_inj = 1'b0;
         cyc++;
         if (b == early_b) begin
            @(negedge clk);
            check("early_err", 64'(err_early_last), 64'd1);
            check("early_busy", 64'(busy), 64'd0);
            check("early_tready", 64'(tready), 64'd1);
            return;
         end
         if (b == rst_b) begin
            @(negedge clk);
            #1;
            tdata  = {$urandom, $urandom};
            tvalid = 1'b1;
            rst    = 1'b1;
            @(posedge clk);
            #1;
            rst    = 1'b0;
            tvalid = 1'b0;
            exp_q.delete();
            exp_frames = 0;
            @(negedge clk);
            check_idle("midreset", 1'b0, 0);
            return;
         end
      end
      @(negedge clk);
      check("cal_num", 64'(cal_num), 64'(cal[CNT_W-1:0]));
   endtask

   task automatic wait_engine(input int target);
      int g = 0;
      while ((exp_frames < target || engine_active) && g < 600) begin
         @(negedge clk);
         g++;
      end
      if (g >= 600) check("engine_wait_timeout", 64'(exp_frames), 64'(target));
   endtask

   initial begin
      tvalid   = 1'b0;
      tlast    = 1'b0;
      tdata    = '0;
      done_inj = 1'b0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset", 1'b0, 0);
      check("reset_cal_num", 64'(cal_num), 64'd0);
      check("reset_wr_data", wr_data, 64'd0);
      mon_en = 1'b1;
      rst    = 1'b0;

      // Continuous frame, CAL_NUM = 3
      send_frame(3, 0, -1, -1, -1, 1'b0);
      wait_engine(1);

      // Same frame shape with a gap every third cycle
      send_frame(3, 1, -1, -1, -1, 1'b0);
      wait_engine(2);

      // Three back-to-back frames; headers stall during WAIT
      reset_dut();
      send_frame(int'($urandom_range(1, 65535)), 2, -1, -1, -1, 1'b1);
      send_frame(0, 2, -1, -1, -1, 1'b0);
      send_frame(int'($urandom_range(1, 65535)), 0, -1, -1, -1, 1'b1);
      wait_engine(3);

      // tlast on weight beat 10 aborts; next frame loads normally
      send_frame(7, 0, 1 + 10, -1, -1, 1'b0);
      repeat (5) @(negedge clk);
      check("no_start_after_abort", 64'(exp_frames), 64'd3);
      send_frame(9, 2, -1, -1, -1, 1'b0);
      wait_engine(4);
      check("err_sticky", 64'(err_early_last), 64'd1);

      // eng_done during LOAD_W must be ignored
      send_frame(5, 0, -1, -1, 30, 1'b0);
      wait_engine(5);

      // Reset during LOAD_V at vector index 20, then a clean frame
      send_frame(11, 0, -1, 1 + WEIGHT_NUM + MAT_ROWS + 20, -1, 1'b0);
      send_frame(12, 1, -1, -1, -1, 1'b0);
      wait_engine(1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/horner_frame_ctrl.md
Name: horner_frame_ctrl

Overview:
- Input-side sequencer for the Horner interpolation engine. Sits between the s00 AXI-Stream slave and the engine's weight, matrix and vector storage.
- Parses each frame as: 1 header beat (CAL_NUM), WEIGHT_NUM weight beats, 3 matrix-row beats, VEC_NUM vector beats. Each beat is steered to the correct store with a running address.
- Once the frame is loaded, pulses start to the engine, then holds the stream off until the engine reports done.

Parameters:
- DATA_WIDTH, 16, lane width in bits.
- LANES, 4, lanes per beat; beat width BEAT_W = LANES*DATA_WIDTH.
- ORI_NUM, 8, orientation entries.
- INT_NUM, 35, interface entries.
- LAY_NUM, 5, layers.
- CNT_W, 16, width of cal_num.
- Derived: WEIGHT_NUM = 3*ORI_NUM+INT_NUM-LAY_NUM+3 (57). VEC_NUM = ORI_NUM+INT_NUM+LAY_NUM+3 (51). MAT_ROWS = 3.

Ports:
- s00_axis_aclk, in, 1, sole clock.
- s00_axis_areset, in, 1, synchronous reset, active-high.
- s00_axis_tdata, in, BEAT_W, frame beat.
- s00_axis_tvalid, in, 1, beat valid.
- s00_axis_tready, out, 1, beat accepted when tvalid && tready.
- s00_axis_tlast, in, 1, optional end-of-frame marker.
- w_we, out, 1, weight write strobe.
- w_addr, out, clog2(WEIGHT_NUM), weight index.
- m_we, out, 1, matrix row write strobe.
- m_row, out, 2, matrix row 0..2.
- v_we, out, 1, vector write strobe.
- v_addr, out, clog2(VEC_NUM), vector index.
- wr_data, out, BEAT_W, shared write data for all three stores.
- cal_num, out, CNT_W, latched header value (tdata[CNT_W-1:0]).
- eng_start, out, 1, one-cycle start pulse.
- eng_done, in, 1, engine completion pulse.
- busy, out, 1, high from header accept until eng_done.
- err_early_last, out, 1, sticky protocol error.
- frame_cnt, out, 8, count of completed frames; wraps at 256.

Behaviour:
- Reset values: all outputs 0 except s00_axis_tready = 1. State IDLE, counters 0. err_early_last cleared only by reset.
- Synchronous reset asserted mid-frame: abandon the frame immediately. No further writes, no eng_start.
- FSM: IDLE -> LOAD_W -> LOAD_M -> LOAD_V -> START -> WAIT -> IDLE.
- IDLE: accepted beat is the header. Latch cal_num, assert busy, go to LOAD_W.
- LOAD_W / LOAD_M / LOAD_V:
  - Each accepted beat produces exactly one write strobe on the following cycle (1-cycle registered latency). wr_data carries the beat; the address is the beat's index within its section.
  - At most one of w_we, m_we, v_we is high in any cycle.
  - The section counter advances only on an accepted beat; tvalid gaps of any length are tolerated.
  - On the last beat of a section, the counter resets to 0 and the FSM moves to the next section.
- Section transitions: beat WEIGHT_NUM-1 -> LOAD_M; row 2 -> LOAD_V; vector beat VEC_NUM-1 -> START.
- s00_axis_tready: 1 in IDLE and the LOAD states, 0 in START and WAIT.
- START: eng_start = 1 for exactly one cycle, which is the cycle after the final v_we. Then go to WAIT.
- WAIT: on eng_done, clear busy, increment frame_cnt, go to IDLE. tready returns high on the next cycle.
- eng_done outside WAIT is ignored.
- eng_done in the same cycle as eng_start is not possible; the engine's minimum latency is 1.
- tlast handling: framing is count-based, and tlast is not required.
  - tlast on the final vector beat: accepted silently.
  - tlast on any other accepted beat, header included: set err_early_last, issue no write for that beat, return to IDLE, drop busy, no eng_start.
- cal_num == 0: frame is loaded normally and eng_start is still issued. The engine treats zero as no-op and returns eng_done.

Decomposition:
- Shared package horner_pkg holds the frame-layout constants: DATA_WIDTH, LANES, ORI_NUM, INT_NUM, LAY_NUM, WEIGHT_NUM, VEC_NUM, MAT_ROWS, and the FSM state enum (6 states, 3 bits).
- Natural sub-module: horner_sec_cnt, a parameterised modulo-N beat counter with inc and terminal-count outputs. Instantiated once and reloaded per section; section length comes from the state.

Test Plan:
- Full frame, CAL_NUM=3, tvalid continuous -> cal_num=3; w_we 57 times with addresses 0..56; m_we rows 0,1,2; v_we 51 times with addresses 0..50. One eng_start exactly 1 cycle after v_addr=50. tready=0 until eng_done; frame_cnt=1.
- Same frame with tvalid deasserted every 3rd cycle -> identical write sequence and data. eng_start is delayed only by the gap cycles.
- Three back-to-back frames with eng_done 20 cycles after each start, and the next header held during WAIT -> header stalls with tready=0. Each frame is processed, and frame_cnt steps 1, 2, 3.
- tlast on weight beat 10 -> err_early_last=1; w_we for addresses 0..9 only; no eng_start. The next header is accepted as a new frame.
- Reset asserted during LOAD_V at v_addr=20 -> next cycle all strobes 0, tready=1, busy=0, state IDLE. A following clean frame completes.
- eng_done pulsed during LOAD_W -> ignored. After the full frame, eng_start occurs and the FSM waits for a fresh eng_done.
